// File: rtl/mc_a_burst_master.sv
// ---------------------------------------------------------------------------
// mc_a_burst_master
//
// Command-driven burst master for the A side of the 8-entry auto-increment
// memory controller. It accepts write/read burst commands and moves the
// controller's free-running address to the requested start slot first. It
// then turns the burst into IncA/WEA/DataInA strobes. Write data arrives on a
// valid/ready stream. Read data leaves on a valid-only stream.
//
// Ports:
//   clock      rising-edge clock
//   Reset      synchronous, active-low reset
//   cmd_valid  command request
//   cmd_ready  high only while idle; the command is taken on valid && ready
//   cmd_write  1 = write burst, 0 = read burst
//   cmd_addr   burst start slot
//   cmd_len    burst length, 0 .. 2*DEPTH-1
//   wr_data    write stream data
//   wr_valid   write stream valid
//   wr_ready   write stream ready (only while writing)
//   rd_data    read stream data, straight from DOut1
//   rd_valid   read stream valid, no backpressure
//   busy       high whenever a command is being worked on
//   done       one-cycle pulse when a burst finishes
//   mem_rst    controller reset, active-high, follows !Reset
//   IncA       controller increment strobe
//   WEA        controller write enable
//   DataInA    controller write data, released (z) when not writing
//   AddrA      controller's current address
//   DOut1      controller read data
// ---------------------------------------------------------------------------
module mc_a_burst_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              mem_rst,
    output logic              IncA,
    output logic              WEA,
    output logic [DATA_W-1:0] DataInA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] DOut1
);

    // Burst lengths run up to 2*DEPTH-1, so the remaining-beat counter
    // needs one more bit than an address.
    localparam int LEN_W = $clog2(2 * DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        WRITE,
        READ,
        FIN
    } state_t;

    state_t            state;
    logic              isWrite;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [ADDR_W-1:0] addrPlusOne;
    logic              driveData;

    // The controller address wraps modulo DEPTH, which the natural
    // ADDR_W-bit overflow gives us.
    assign addrPlusOne = AddrA + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Status flags are decoded straight from the state register.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign wr_ready  = (state == WRITE);
    assign rd_data   = DOut1;
    assign mem_rst   = ~Reset;

    // Controller strobes. They are gated by Reset so that a reset in the
    // middle of a burst stops all strobes at once. In SEEK the increment is
    // suppressed if the address already matches. A write stall keeps WEA
    // high but drops IncA and releases the data bus. The controller treats
    // that as a no-op.
    always_comb begin
        IncA      = 1'b0;
        WEA       = 1'b0;
        driveData = 1'b0;
        if (Reset) begin
            case (state)
                SEEK: begin
                    IncA = (AddrA != addr);
                end
                WRITE: begin
                    WEA       = 1'b1;
                    IncA      = wr_valid;
                    driveData = wr_valid;
                end
                READ: begin
                    IncA = 1'b1;
                end
                default: begin
                    IncA = 1'b0;
                end
            endcase
        end
    end

    assign DataInA = driveData ? wr_data : {DATA_W{1'bz}};

    // Main sequencer.
    // rd_valid is registered on the same edge that loads DOut1 in the
    // controller, so each read beat appears one cycle after its issue.
    // The SEEK exit looks one address ahead, so the burst starts on the
    // cycle right after the last seek increment.
    always_ff @(posedge clock) begin
        if (!Reset) begin
            state    <= IDLE;
            isWrite  <= 1'b0;
            addr     <= '0;
            rem      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        isWrite <= cmd_write;
                        addr    <= cmd_addr;
                        rem     <= cmd_len;
                        if (cmd_len == '0)
                            state <= FIN;
                        else if (AddrA != cmd_addr)
                            state <= SEEK;
                        else
                            state <= cmd_write ? WRITE : READ;
                    end
                end
                SEEK: begin
                    if ((AddrA == addr) || (addrPlusOne == addr))
                        state <= isWrite ? WRITE : READ;
                end
                WRITE: begin
                    if (wr_valid) begin
                        rem <= rem - 1'b1;
                        if (rem == {{(LEN_W-1){1'b0}}, 1'b1})
                            state <= FIN;
                    end
                end
                READ: begin
                    rem <= rem - 1'b1;
                    if (rem == {{(LEN_W-1){1'b0}}, 1'b1})
                        state <= FIN;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_a_burst_master.sv
// ---------------------------------------------------------------------------
// tb_mc_a_burst_master
//
// Self-checking bench for mc_a_burst_master. The bench contains a small
// model of the auto-increment memory controller, so the master has a real
// AddrA/DOut1 to work against. Each command is expanded up front into the
// exact per-cycle outputs the master should show, using transaction rules:
// seek distance, beat count, write stalls, and read latency. A compare
// process checks every cycle against that expansion. A few literal checks
// on the controller model pin the expected memory contents and addresses.
// ---------------------------------------------------------------------------
module tb_mc_a_burst_master;

    logic       clock;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       mem_rst;
    logic       IncA;
    logic       WEA;
    wire  [7:0] DataInA;
    logic [2:0] ctrlAddr;
    logic [7:0] DOut1;

    logic [7:0] ctrlMem [8];
    logic [7:0] refMem [8];
    int         refAddr;

    int testsRun;
    int testsFailed;
    int cycleNo;

    typedef struct {
        bit         skip;
        bit         rstLow;
        bit         cmdValid;
        bit         cmdWrite;
        logic [2:0] cmdAddr;
        logic [3:0] cmdLen;
        bit         wrValid;
        logic [7:0] wrData;
        bit   [7:0] ctl;
        logic [7:0] rdData;
        logic [7:0] dataIn;
    } cyc_t;

    cyc_t       expQ [$];
    logic [7:0] capQ [$];
    logic [7:0] fixedData [$];

    mc_a_burst_master dut (
        .clock     (clock),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .mem_rst   (mem_rst),
        .IncA      (IncA),
        .WEA       (WEA),
        .DataInA   (DataInA),
        .AddrA     (ctrlAddr),
        .DOut1     (DOut1)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model of the auto-increment controller. Every cycle it reads (DOut1
    // refresh). It writes only when a data strobe (IncA with WEA) is present.
    // It advances when IncA is high. mem_rst parks it at address 0.
    always @(posedge clock) begin
        if (mem_rst) begin
            ctrlAddr <= 3'd0;
            DOut1    <= 8'h00;
        end else begin
            DOut1 <= ctrlMem[ctrlAddr];
            if (IncA && WEA)
                ctrlMem[ctrlAddr] <= DataInA;
            if (IncA)
                ctrlAddr <= ctrlAddr + 3'd1;
        end
    end

    // Count each comparison, and report any miss on one line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, cycleNo, act, exp);
        end
    endtask

    // One expected cycle. Inputs that the master must ignore in this cycle
    // are filled with random junk.
    function automatic cyc_t mk(bit cr, bit bsy, bit inc, bit we, bit wrr, bit rv, bit dn);
        cyc_t e;
        e.skip     = 1'b0;
        e.rstLow   = 1'b0;
        e.cmdValid = 1'($urandom_range(0, 1));
        e.cmdWrite = 1'($urandom_range(0, 1));
        e.cmdAddr  = 3'($urandom_range(0, 7));
        e.cmdLen   = 4'($urandom_range(0, 15));
        e.wrValid  = 1'($urandom_range(0, 1));
        e.wrData   = 8'($urandom);
        e.ctl      = {cr, bsy, inc, we, wrr, rv, dn, 1'b0};
        e.rdData   = 8'h00;
        e.dataIn   = 8'h00;
        return e;
    endfunction

    // Drive one cycle's inputs just after the active edge, and queue what
    // the outputs must be in that cycle.
    task automatic applyStimulus(input cyc_t e);
        @(posedge clock);
        #1;
        Reset     = ~e.rstLow;
        cmd_valid = e.cmdValid;
        cmd_write = e.cmdWrite;
        cmd_addr  = e.cmdAddr;
        cmd_len   = e.cmdLen;
        wr_valid  = e.wrValid;
        wr_data   = e.wrData;
        expQ.push_back(e);
    endtask

    task automatic doReset(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e        = mk(0, 0, 0, 0, 0, 0, 0);
            e.skip   = 1'b1;
            e.rstLow = 1'b1;
            applyStimulus(e);
        end
        refAddr = 0;
    endtask

    task automatic idleCycles(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e          = mk(1, 0, 0, 0, 0, 0, 0);
            e.cmdValid = 1'b0;
            applyStimulus(e);
        end
    endtask

    // Expand one command into its cycle trace and run it. useMask picks the
    // wr_valid pattern per WRITE cycle (bit k = cycle k). abortAt > 0 means
    // the command is cut by a reset at that cycle index (reads only).
    task automatic runCmd(input bit w, input int a, input int l, input bit useMask,
                          input logic [31:0] mask, input int abortAt);
        cyc_t q [$];
        cyc_t e;
        int   n;
        int   k;
        int   beats;
        bit   v;
        logic [7:0] d;
        bit   aborted;

        e          = mk(1, 0, 0, 0, 0, 0, 0);
        e.cmdValid = 1'b1;
        e.cmdWrite = w;
        e.cmdAddr  = 3'(a);
        e.cmdLen   = 4'(l);
        q.push_back(e);

        if (l == 0) begin
            q.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        end else begin
            n = (a - refAddr) & 7;
            for (int i = 0; i < n; i++)
                q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
            if (w) begin
                beats = 0;
                k     = 0;
                while (beats < l) begin
                    if (useMask)
                        v = (k < 32) ? mask[k] : 1'b1;
                    else
                        v = ($urandom_range(0, 3) != 0);
                    d = 8'($urandom);
                    if (v && fixedData.size() > 0)
                        d = fixedData.pop_front();
                    e         = mk(0, 1, v, 1, 1, 0, 0);
                    e.wrValid = v;
                    e.wrData  = d;
                    e.dataIn  = d;
                    if (v) begin
                        refMem[(a + beats) & 7] = d;
                        beats++;
                    end
                    k++;
                    q.push_back(e);
                end
                q.push_back(mk(0, 1, 0, 0, 0, 0, 1));
            end else begin
                for (int j = 0; j < l; j++) begin
                    e = mk(0, 1, 1, 0, 0, (j > 0), 0);
                    if (j > 0)
                        e.rdData = refMem[(a + j - 1) & 7];
                    q.push_back(e);
                end
                e        = mk(0, 1, 0, 0, 0, 1, 1);
                e.rdData = refMem[(a + l - 1) & 7];
                q.push_back(e);
            end
        end

        aborted = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (abortAt > 0 && i == abortAt) begin
                aborted = 1'b1;
                break;
            end
            applyStimulus(q[i]);
        end

        if (aborted)
            doReset(1);
        else if (l != 0)
            refAddr = (a + l) & 7;
    endtask

    // Per-cycle compare against the expanded trace. Outputs are sampled on
    // the falling edge, well away from the active edge. During reset cycles
    // only mem_rst is meaningful.
    always @(negedge clock) begin
        cyc_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.skip) begin
                checkOutput("mem_rst", {31'd0, mem_rst}, 32'd1);
            end else begin
                checkOutput("ctl{cmd_ready,busy,IncA,WEA,wr_ready,rd_valid,done,mem_rst}",
                            {24'd0, cmd_ready, busy, IncA, WEA, wr_ready, rd_valid, done, mem_rst},
                            {24'd0, e.ctl});
                if (e.ctl[2])
                    checkOutput("rd_data", {24'd0, rd_data}, {24'd0, e.rdData});
                if (e.ctl[5] && e.ctl[4])
                    checkOutput("DataInA", {24'd0, DataInA}, {24'd0, e.dataIn});
                if (rd_valid)
                    capQ.push_back(rd_data);
            end
        end
        cycleNo++;
    end

    initial begin
        int a;
        int l;
        testsRun    = 0;
        testsFailed = 0;
        cycleNo     = 0;
        refAddr     = 0;
        ctrlAddr    = 3'd0;
        Reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = 3'd0;
        cmd_len     = 4'd0;
        wr_valid    = 1'b0;
        wr_data     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ctrlMem[i] = 8'h00;
            refMem[i]  = 8'h00;
        end

        // Reset, then idle.
        doReset(2);
        idleCycles(2);
        checkOutput("addrAfterReset", {29'd0, ctrlAddr}, 32'd0);

        // Back-to-back write of four bytes at slot 0.
        fixedData = '{8'h11, 8'h22, 8'h33, 8'h44};
        runCmd(1, 0, 4, 1, 32'h0000_000F, 0);
        idleCycles(1);
        checkOutput("addrAfterWrite4", {29'd0, ctrlAddr}, 32'd4);

        // Read back from slot 0. This needs a four-cycle seek from 4.
        capQ.delete();
        runCmd(0, 0, 4, 0, 32'h0, 0);
        idleCycles(1);
        checkOutput("read4Count", capQ.size(), 32'd4);
        if (capQ.size() == 4) begin
            checkOutput("read4Beat0", {24'd0, capQ[0]}, 32'h11);
            checkOutput("read4Beat1", {24'd0, capQ[1]}, 32'h22);
            checkOutput("read4Beat2", {24'd0, capQ[2]}, 32'h33);
            checkOutput("read4Beat3", {24'd0, capQ[3]}, 32'h44);
        end

        // Write of three bytes with a two-cycle stall after the first beat.
        fixedData = '{8'h51, 8'h52, 8'h53};
        runCmd(1, 4, 3, 1, 32'h0000_0019, 0);
        idleCycles(1);
        checkOutput("addrAfterStall", {29'd0, ctrlAddr}, 32'd7);
        checkOutput("stallSlot4", {24'd0, ctrlMem[4]}, 32'h51);
        checkOutput("stallSlot5", {24'd0, ctrlMem[5]}, 32'h52);
        checkOutput("stallSlot6", {24'd0, ctrlMem[6]}, 32'h53);
        checkOutput("stallSlot7", {24'd0, ctrlMem[7]}, 32'h00);

        // Wrapping write and read at slot 6.
        fixedData = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        runCmd(1, 6, 4, 1, 32'h0000_000F, 0);
        capQ.delete();
        runCmd(0, 6, 4, 0, 32'h0, 0);
        idleCycles(1);
        checkOutput("wrapCount", capQ.size(), 32'd4);
        if (capQ.size() == 4) begin
            checkOutput("wrapBeat0", {24'd0, capQ[0]}, 32'hA0);
            checkOutput("wrapBeat3", {24'd0, capQ[3]}, 32'hA3);
        end
        checkOutput("addrAfterWrap", {29'd0, ctrlAddr}, 32'd2);

        // A zero-length command does not move the address.
        runCmd(1, 3, 0, 0, 32'h0, 0);
        idleCycles(1);
        checkOutput("addrAfterLen0", {29'd0, ctrlAddr}, 32'd2);

        // A reset two beats into a five-beat read aborts the burst.
        runCmd(0, 2, 5, 0, 32'h0, 3);
        idleCycles(2);
        checkOutput("addrAfterAbort", {29'd0, ctrlAddr}, 32'd0);

        // Random commands, including long wrapping bursts and back-to-back
        // starts at the current address.
        for (int t = 0; t < 60; t++) begin
            a = ($urandom_range(0, 2) == 0) ? refAddr : $urandom_range(0, 7);
            l = $urandom_range(0, 15);
            runCmd(1'($urandom_range(0, 1)), a, l, 0, 32'h0, 0);
            idleCycles($urandom_range(0, 2));
        end

        idleCycles(2);
        for (int i = 0; i < 8; i++)
            checkOutput("finalMem", {24'd0, ctrlMem[i]}, {24'd0, refMem[i]});
        checkOutput("finalAddr", {29'd0, ctrlAddr}, 32'(refAddr));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
